// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, decade limits and a load clamp helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Any nibble above 9 is not a decimal digit; it is forced to the largest legal one.
  function automatic bcd_digit_t bcd_sat(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter.
// master = whoever drives the controls, slave = the counter itself.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);

  logic                  sync_clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic                  up;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  load_err;

  modport master (
    output sync_clr, load, load_val, en, up,
    input  count, tc, load_err
  );

  modport slave (
    input  sync_clr, load, load_val, en, up,
    output count, tc, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade. step_in is the ripple enable from the lower decades;
// step_out tells the next decade that this one is about to wrap.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       step_in,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       sync_clr,
  output bcd_digit_t digit,
  output logic       step_out
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next digit value: clear beats load beats step; otherwise hold.
  always_comb begin
    digit_d = digit_q;
    if (sync_clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = bcd_sat(load_digit);
    end else if (step_in) begin
      if (up) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit register, cleared asynchronously by clr low.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  // A stepping decade sitting at its terminal value carries/borrows into the next one.
  assign step_out = step_in & (up ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));
  assign digit    = digit_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// DIGITS-decade BCD up/down counter built from a ripple-enabled chain of
// bcd_digit instances. Legal DIGITS range is 1..8.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  bcd_updown_counter_if.slave  bus
);

  logic [DIGITS:0]     step;
  logic [DIGITS-1:0]   digit_bad;
  logic [4*DIGITS-1:0] count_w;
  bcd_digit_t          digit_w [DIGITS];
  logic                load_err_q;
  logic                load_err_d;

  // The count enable is the carry/borrow into decade 0.
  assign step[0] = bus.en;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk        (clk),
        .clr        (clr),
        .step_in    (step[gi]),
        .up         (bus.up),
        .load       (bus.load),
        .load_digit (bus.load_val[4*gi +: 4]),
        .sync_clr   (bus.sync_clr),
        .digit      (digit_w[gi]),
        .step_out   (step[gi+1])
      );

      assign count_w[4*gi +: 4] = digit_w[gi];
      assign digit_bad[gi]      = (bus.load_val[4*gi +: 4] > BCD_MAX);
    end
  endgenerate

  // Flag a load that had to clamp at least one non-decimal digit.
  always_comb begin
    load_err_d = bus.load & ~bus.sync_clr & (|digit_bad);
  end

  // One-cycle load error flag, cleared asynchronously with the count.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_w;
  assign bus.load_err = load_err_q;
  // Carry out of the top decade means the enabled step wraps; a pending
  // clear/load or an active reset overrides the step, so no terminal count then.
  assign bus.tc       = clr & ~bus.sync_clr & ~bus.load & step[DIGITS];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: arithmetic reference model compared every cycle for
// 4-, 2- and 1-decade counters, plus directed literal checks.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(4)) bus4 ();
  bcd_updown_counter_if #(.DIGITS(2)) bus2 ();
  bcd_updown_counter_if #(.DIGITS(1)) bus1 ();

  bcd_updown_counter #(.DIGITS(4)) dut4 (.clk(clk), .clr(clr), .bus(bus4));
  bcd_updown_counter #(.DIGITS(2)) dut2 (.clk(clk), .clr(clr), .bus(bus2));
  bcd_updown_counter #(.DIGITS(1)) dut1 (.clk(clk), .clr(clr), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------------
  function automatic int unsigned pow10(input int d);
    int unsigned r = 1;
    for (int k = 0; k < d; k++) r = r * 10;
    return r;
  endfunction

  function automatic int unsigned to_int(input logic [31:0] v, input int d);
    int unsigned r = 0;
    for (int k = d - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned n, input int d);
    logic [31:0] r = '0;
    int unsigned x = n;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] cur, input logic sclr, input logic ld,
                                         input logic [31:0] lv, input logic en, input logic up,
                                         input int d);
    logic [31:0] r = '0;
    int unsigned m = pow10(d);
    if (sclr) return '0;
    if (ld) begin
      for (int k = 0; k < d; k++) r[4*k +: 4] = (lv[4*k +: 4] > 4'd9) ? 4'd9 : lv[4*k +: 4];
      return r;
    end
    if (en) return to_bcd(up ? (to_int(cur, d) + 1) % m : (to_int(cur, d) + m - 1) % m, d);
    return cur;
  endfunction

  function automatic logic m_err(input logic sclr, input logic ld, input logic [31:0] lv, input int d);
    logic bad = 1'b0;
    for (int k = 0; k < d; k++) if (lv[4*k +: 4] > 4'd9) bad = 1'b1;
    return ld && !sclr && bad;
  endfunction

  function automatic logic m_tc(input logic [31:0] cur, input logic rn, input logic sclr, input logic ld,
                                input logic en, input logic up, input int d);
    return rn && en && !sclr && !ld &&
           (up ? (to_int(cur, d) == pow10(d) - 1) : (to_int(cur, d) == 0));
  endfunction

  logic [31:0] exp4 = '0, exp2 = '0, exp1 = '0;
  logic        err4 = 1'b0, err2 = 1'b0, err1 = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      exp4 <= '0; exp2 <= '0; exp1 <= '0;
      err4 <= 1'b0; err2 <= 1'b0; err1 <= 1'b0;
    end else begin
      exp4 <= m_next(exp4, bus4.sync_clr, bus4.load, 32'(bus4.load_val), bus4.en, bus4.up, 4);
      exp2 <= m_next(exp2, bus2.sync_clr, bus2.load, 32'(bus2.load_val), bus2.en, bus2.up, 2);
      exp1 <= m_next(exp1, bus1.sync_clr, bus1.load, 32'(bus1.load_val), bus1.en, bus1.up, 1);
      err4 <= m_err(bus4.sync_clr, bus4.load, 32'(bus4.load_val), 4);
      err2 <= m_err(bus2.sync_clr, bus2.load, 32'(bus2.load_val), 2);
      err1 <= m_err(bus1.sync_clr, bus1.load, 32'(bus1.load_val), 1);
    end
  end

  // Compare process: one sample 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    check("cnt4", 32'(bus4.count), exp4);
    check("err4", 32'(bus4.load_err), 32'(err4));
    check("tc4",  32'(bus4.tc), 32'(m_tc(exp4, clr, bus4.sync_clr, bus4.load, bus4.en, bus4.up, 4)));
    check("cnt2", 32'(bus2.count), exp2);
    check("err2", 32'(bus2.load_err), 32'(err2));
    check("tc2",  32'(bus2.tc), 32'(m_tc(exp2, clr, bus2.sync_clr, bus2.load, bus2.en, bus2.up, 2)));
    check("cnt1", 32'(bus1.count), exp1);
    check("err1", 32'(bus1.load_err), 32'(err1));
    check("tc1",  32'(bus1.tc), 32'(m_tc(exp1, clr, bus1.sync_clr, bus1.load, bus1.en, bus1.up, 1)));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    int tc_hits;
    bus4.sync_clr = 0; bus4.load = 0; bus4.load_val = '0; bus4.en = 0; bus4.up = 1;
    bus2.sync_clr = 0; bus2.load = 0; bus2.load_val = '0; bus2.en = 0; bus2.up = 1;
    bus1.sync_clr = 0; bus1.load = 0; bus1.load_val = '0; bus1.en = 0; bus1.up = 1;
    #2 clr = 1'b0;
    #1;
    check("rst_cnt4", 32'(bus4.count), 32'h0);
    check("rst_err4", 32'(bus4.load_err), 32'h0);
    bus4.en = 1;
    #1 check("rst_tc4", 32'(bus4.tc), 32'h0);
    bus4.en = 0;
    repeat (2) @(negedge clk);
    clr = 1'b1;

    // Full up-count over all 10000 states.
    bus4.en = 1; bus4.up = 1; tc_hits = 0;
    for (int i = 0; i < 10000; i++) begin
      #1;
      if (bus4.tc) begin
        tc_hits++;
        check("tc_at_9999", 32'(bus4.count), 32'h9999);
      end
      @(negedge clk);
    end
    #1;
    check("tc_hits", 32'(tc_hits), 32'd1);
    check("wrap_up", 32'(bus4.count), 32'h0000);

    // Load 0100 then count down through 0000 into 9999.
    bus4.load = 1; bus4.load_val = 16'h0100; bus4.up = 0;
    @(negedge clk); bus4.load = 0; #1;
    check("ld_0100", 32'(bus4.count), 32'h0100);
    @(negedge clk); #1 check("dn_0099", 32'(bus4.count), 32'h0099);
    @(negedge clk); #1 check("dn_0098", 32'(bus4.count), 32'h0098);
    repeat (98) @(negedge clk);
    #1;
    check("dn_0000", 32'(bus4.count), 32'h0000);
    check("tc_0000", 32'(bus4.tc), 32'h1);
    @(negedge clk); #1;
    check("wrap_dn", 32'(bus4.count), 32'h9999);
    check("tc_9999_dn", 32'(bus4.tc), 32'h0);

    // Clear beats load and enable on the same edge.
    bus4.sync_clr = 1; bus4.load = 1; bus4.load_val = 16'h1234; bus4.up = 1;
    #1 check("tc_gated", 32'(bus4.tc), 32'h0);
    @(negedge clk); #1;
    check("sclr_wins", 32'(bus4.count), 32'h0000);
    bus4.sync_clr = 0; bus4.en = 0;
    @(negedge clk); #1;
    check("ld_1234", 32'(bus4.count), 32'h1234);
    check("ld_ok_err", 32'(bus4.load_err), 32'h0);

    // Clamped load on the 4-decade counter.
    bus4.load_val = 16'hF0A5;
    @(negedge clk); bus4.load = 0; #1;
    check("ld_clamp4", 32'(bus4.count), 32'h9095);
    check("ld_err4", 32'(bus4.load_err), 32'h1);

    // Asynchronous clear in the middle of an up-count.
    bus4.load = 1; bus4.load_val = 16'h0509; bus4.en = 1; bus4.up = 1;
    @(negedge clk); bus4.load = 0; #1;
    check("ld_0509", 32'(bus4.count), 32'h0509);
    #1 clr = 1'b0;
    #1;
    check("aclr_cnt", 32'(bus4.count), 32'h0000);
    check("aclr_tc", 32'(bus4.tc), 32'h0);
    @(negedge clk); #1;
    check("aclr_hold", 32'(bus4.count), 32'h0000);
    clr = 1'b1;
    @(negedge clk); #1;
    check("first_step", 32'(bus4.count), 32'h0001);
    bus4.en = 0;

    // Two decades: 0x3C loads as 0x39 with a one-cycle error flag.
    bus2.load = 1; bus2.load_val = 8'h3C;
    @(negedge clk); bus2.load = 0; #1;
    check("ld_3c", 32'(bus2.count), 32'h39);
    check("ld_err2_on", 32'(bus2.load_err), 32'h1);
    @(negedge clk); #1;
    check("ld_err2_off", 32'(bus2.load_err), 32'h0);
    check("hold_39", 32'(bus2.count), 32'h39);

    // One decade: direction toggled every edge from 9.
    bus1.load = 1; bus1.load_val = 4'h9;
    @(negedge clk); bus1.load = 0; bus1.en = 1; bus1.up = 1; #1;
    check("d1_start", 32'(bus1.count), 32'h9);
    check("d1_tc0", 32'(bus1.tc), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus1.up = ~bus1.up;
      #1;
      check("d1_cnt", 32'(bus1.count), (i % 2 == 0) ? 32'h0 : 32'h9);
      check("d1_tc", 32'(bus1.tc), 32'h1);
    end
    bus1.up = ~bus1.up;
    #1 check("d1_tc_wrongdir", 32'(bus1.tc), 32'h0);
    bus1.en = 0;
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, sets the number of cascaded BCD decades (legal range 1..8).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 sync_clr  input  1  synchronous clear to zero, active-high.
REQ-005 load  input  1  synchronous parallel load strobe, active-high.
REQ-006 load_val  input  4*DIGITS  value to load, digit k in bits [4k+3:4k], digit 0 least significant.
REQ-007 en  input  1  count enable, active-high.
REQ-008 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 count  output  4*DIGITS  registered BCD count, same digit packing as load_val.
REQ-010 tc  output  1  terminal count, combinational: high when en=1 and the next enabled step wraps.
REQ-011 load_err  output  1  registered one-cycle flag: previous load contained a digit above 9.

Function
REQ-012 Per-edge priority SHALL be sync_clr > load > en; with none asserted, count SHALL hold.
REQ-013 sync_clr=1: count becomes 0 on the next edge, regardless of load/en/up.
REQ-014 load=1 (sync_clr=0): each digit of load_val <= 9 SHALL be loaded as-is; any digit > 9 SHALL be loaded as 9.
REQ-015 load_err SHALL be 1 for exactly the cycle after a load edge with any digit > 9, and 0 otherwise.
REQ-016 en=1, up=1: digit 0 increments; digit k increments only when all lower digits are 9; a digit at 9 that increments SHALL become 0.
REQ-017 en=1, up=0: digit 0 decrements; digit k decrements only when all lower digits are 0; a digit at 0 that decrements SHALL become 9.
REQ-018 Wrap-around: all-9s counting up SHALL become all-0s, and all-0s counting down SHALL become all-9s, in one edge.
REQ-019 tc SHALL be 1 iff en=1 and either (up=1 and count is all 9s) or (up=0 and count is all 0s); tc SHALL be 0 while sync_clr or load is 1.
REQ-020 Latency: count SHALL reflect any clear, load or step on the edge it is sampled; there SHALL be no additional pipeline stages.
REQ-021 A change of up SHALL take effect on the very next enabled edge, with no dead cycle.
REQ-022 count SHALL never hold a digit above 9 in any reachable state.

Reset
REQ-023 clr=0 SHALL immediately force count=0 and load_err=0, independent of clk.
REQ-024 tc SHALL be 0 while clr=0.
REQ-025 Deassertion of clr mid-operation SHALL leave count at 0, with the first step taken on the first rising edge where clr=1 and en=1.

Structure
REQ-026 A shared package bcd_pkg SHALL hold the BCD_MAX (9) and BCD_MIN (0) constants and the 4-bit digit type.
REQ-027 One sub-module, bcd_digit, SHALL implement a single decade with inputs step_in, up, load, load_digit, sync_clr and outputs digit, step_out; the top SHALL chain DIGITS instances via step_out -> step_in.
REQ-028 step_out of each bcd_digit SHALL be combinational (step_in AND digit at terminal for the direction), giving a ripple-enable, fully synchronous design.

Verification
REQ-029 DIGITS=4: clr pulse, then en=1, up=1 for 10000 edges -> count steps 0000..9999 then back to 0000; tc high only at 9999.
REQ-030 DIGITS=4: load 0100, en=1, up=0 -> 0099, 0098 on successive edges; at 0000 tc=1 and the next edge gives 9999.
REQ-031 DIGITS=2: load_val=0x3C with load=1 -> count=0x39, load_err=1 for one cycle, then 0.
REQ-032 DIGITS=4: same edge sync_clr=1, load=1 (0x1234), en=1 -> count=0000; next edge with load only -> 1234.
REQ-033 DIGITS=4: count=0509 counting up; assert clr=0 between edges -> count=0000 immediately; release -> next enabled edge gives 0001.
REQ-034 DIGITS=1: en=1, up toggled every edge starting at 9 -> 0, 9, 0, 9, with tc tracking REQ-019 each cycle.
